reg_bank_arbiter: RTL and testbench

Round-robin write arbiter and controller for a small bank of enabled storage registers shared by several requesters. Each requester presents an address/data write request; the block picks one winner per arbitration round, drives the write enable of the addressed bank word, and acknowledges the winner with a one-cycle grant. A registered read port exposes the bank to the consuming datapath.

---
 rtl/reg_bank_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/reg_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_arb_pkg
// Shared types and helpers for the register-bank write arbiter.
//   state_e  : arbiter FSM state encoding (ST_IDLE / ST_WRITE)
//   rr_next  : (idx + 1) mod n, written as an explicit compare so that any
//              requester count works, not only powers of two
// -----------------------------------------------------------------------------
package reg_bank_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned n);
        if (idx == n - 1) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. Scans i_ptr, i_ptr+1, ... with
// wrap modulo REQ_NUM; the first requester with its request high wins.
// Ports:
//   i_req    [REQ_NUM-1:0]  request vector
//   i_ptr    [IDX_W-1:0]    search start index (must be < REQ_NUM)
//   o_onehot [REQ_NUM-1:0]  one-hot winner, zero when no request
//   o_idx    [IDX_W-1:0]    winner index, zero when no request
//   o_valid                 at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned REQ_NUM = 4,
    parameter int unsigned IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [REQ_NUM-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // One extra bit so ptr + offset never overflows before the wrap compare.
    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(REQ_NUM);

    always_comb begin : p_search
        logic [IDX_W:0] w_sum;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_sum    = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= N_W) begin
                w_sum = w_sum - N_W;
            end
            if (!o_valid && i_req[w_sum[IDX_W-1:0]]) begin
                o_valid                     = 1'b1;
                o_idx                       = w_sum[IDX_W-1:0];
                o_onehot[w_sum[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter
// Round-robin write arbiter for a small register bank shared by REQ_NUM
// requesters, with a registered read port.
// IDLE picks a winner; WRITE raises gnt_o/busy_o for one cycle and commits the
// winner's address/data at the closing edge, then returns to IDLE.
// Ports:
//   clk_i      clock, rising edge
//   s_rst_i    synchronous active-high reset
//   req_i      [REQ_NUM]              per-requester write request (level)
//   addr_i     [REQ_NUM*ADDR_WIDTH]   per-requester word address
//   data_i     [REQ_NUM*DATA_WIDTH]   per-requester write data
//   lock_i     [REQ_NUM]              grant lock (only with REG_BANK_ARB_LOCK_EN)
//   gnt_o      [REQ_NUM]              registered one-hot acknowledge
//   busy_o                            high in WRITE
//   rd_addr_i  [ADDR_WIDTH]           read address
//   rd_data_o  [DATA_WIDTH]           registered read data (read-before-write)
// Optional feature macro: REG_BANK_ARB_LOCK_EN
// -----------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                          clk_i,
    input  logic                          s_rst_i,
    input  logic [REQ_NUM-1:0]            req_i,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0] addr_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] data_i,
`ifdef REG_BANK_ARB_LOCK_EN
    input  logic [REQ_NUM-1:0]            lock_i,
`endif
    output logic [REQ_NUM-1:0]            gnt_o,
    output logic                          busy_o,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o
);

    localparam int unsigned IDX_W = $clog2(REQ_NUM);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_e                r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]      r_win, w_win_nxt;
    logic [REQ_NUM-1:0]    r_gnt, w_gnt_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [DATA_WIDTH-1:0] r_bank [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;

    logic [REQ_NUM-1:0]    w_arb_onehot;
    logic [IDX_W-1:0]      w_arb_idx;
    logic                  w_arb_valid;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_lock;

    rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_arb_onehot),
        .o_idx    (w_arb_idx),
        .o_valid  (w_arb_valid)
    );

    // Winner's address/data/lock are taken live at the WRITE-closing edge,
    // not captured at arbitration.
    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_lock  = 1'b0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            if (r_win == IDX_W'(k)) begin
                w_waddr = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = data_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef REG_BANK_ARB_LOCK_EN
                w_lock  = lock_i[k];
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_WRITE;
                    w_win_nxt   = w_arb_idx;
                    w_gnt_nxt   = w_arb_onehot;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_WRITE: begin
                w_we        = 1'b1;
                w_state_nxt = ST_IDLE;
                // A locked winner keeps the pointer so it is searched first again.
                w_ptr_nxt   = w_lock ? r_win
                                     : IDX_W'(rr_next(32'(r_win), REQ_NUM));
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Read samples the pre-edge bank contents, so a same-word write on the
    // same edge returns the old value.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_rd <= '0;
        end else begin
            r_rd <= r_bank[rd_addr_i];
            if (w_we) begin
                r_bank[w_waddr] <= w_wdata;
            end
        end
    end

    assign gnt_o     = r_gnt;
    assign busy_o    = r_busy;
    assign rd_data_o = r_rd;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_arbiter
// Directed vector table, hand-written rotation/lock sequences, then random
// traffic checked against a transaction-level model of the arbiter.
// Optional feature macro: REG_BANK_ARB_LOCK_EN
// -----------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    lock;
    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [DW-1:0]   rd_data;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .REQ_NUM    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i     (clk),
        .s_rst_i   (rst),
        .req_i     (req),
        .addr_i    (addr),
        .data_i    (data),
`ifdef REG_BANK_ARB_LOCK_EN
        .lock_i    (lock),
`endif
        .gnt_o     (gnt),
        .busy_o    (busy),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    typedef struct {
        logic            rst;
        logic [N-1:0]    req;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic [AW-1:0]   rd_addr;
        logic [N-1:0]    gnt;
        logic            busy;
        logic [DW-1:0]   rd;
    } vec_t;

    vec_t tbl [19];

    // ---------------- reference model (transaction level) ----------------
    bit            m_wr;
    int            m_win;
    int            m_ptr;
    logic [DW-1:0] m_bank [1 << AW];
    logic [DW-1:0] m_rd;
    bit            pend   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];

    task automatic model_step(output int done);
        logic [DW-1:0] nrd;
        bit lk;
        done = -1;
        if (rst) begin
            m_wr  = 0;
            m_ptr = 0;
            m_win = 0;
            m_rd  = '0;
            foreach (m_bank[i]) m_bank[i] = '0;
        end else begin
            nrd = m_bank[rd_addr];
            if (m_wr) begin
                m_bank[addr[m_win*AW +: AW]] = data[m_win*DW +: DW];
`ifdef REG_BANK_ARB_LOCK_EN
                lk = lock[m_win];
`else
                lk = 0;
`endif
                m_ptr = lk ? m_win : (m_win + 1) % N;
                m_wr  = 0;
                done  = m_win;
            end else if (req != '0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (req[k]) begin
                        m_win = k;
                        m_wr  = 1;
                        break;
                    end
                end
            end
            m_rd = nrd;
        end
    endtask

    initial begin
        int gcount [N];
        int done;
        logic [N-1:0] eg;

        //          rst   req    addr   data          rd    gnt    busy  rd
        tbl[0]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'h2, 8'h04, 32'h0000A500, 2'd1, 4'h2, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 4'h2, 8'h04, 32'h0000A500, 2'd1, 4'h0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 2'd1, 4'h0, 1'b0, 8'hA5};
        tbl[4]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 2'd2, 4'h0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 4'hA, 8'h88, 32'h33001100, 2'd2, 4'h2, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, 4'hA, 8'h88, 32'h33001100, 2'd2, 4'h0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 4'h8, 8'h88, 32'h33001100, 2'd2, 4'h8, 1'b1, 8'h11};
        tbl[8]  = '{1'b0, 4'h8, 8'h88, 32'h33001100, 2'd2, 4'h0, 1'b0, 8'h11};
        tbl[9]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 2'd2, 4'h0, 1'b0, 8'h33};
        tbl[10] = '{1'b0, 4'h1, 8'h03, 32'h00000012, 2'd3, 4'h1, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 4'h1, 8'h03, 32'h00000012, 2'd3, 4'h0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 4'h1, 8'h03, 32'h00000034, 2'd3, 4'h1, 1'b1, 8'h12};
        tbl[13] = '{1'b0, 4'h1, 8'h03, 32'h00000034, 2'd3, 4'h0, 1'b0, 8'h12};
        tbl[14] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 2'd3, 4'h0, 1'b0, 8'h34};
        tbl[15] = '{1'b0, 4'h4, 8'h00, 32'h00FF0000, 2'd0, 4'h4, 1'b1, 8'h00};
        tbl[16] = '{1'b1, 4'h4, 8'h00, 32'h00FF0000, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[17] = '{1'b0, 4'hA, 8'h00, 32'h00000000, 2'd3, 4'h2, 1'b1, 8'h00};
        tbl[18] = '{1'b0, 4'hA, 8'h00, 32'h00000000, 2'd0, 4'h0, 1'b0, 8'h00};

        lock = '0;
        for (int i = 0; i < 19; i++) begin
            rst     = tbl[i].rst;
            req     = tbl[i].req;
            addr    = tbl[i].addr;
            data    = tbl[i].data;
            rd_addr = tbl[i].rd_addr;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(tbl[i].rd));
        end

        // All requesters active from ptr=0: grants 0,1,2,3,0 two cycles apart.
        rst = 1'b1; req = '0; addr = '0; data = '0; rd_addr = '0;
        @(posedge clk); @(negedge clk);
        check("rot_reset_gnt", 32'(gnt), 32'h0);
        rst = 1'b0; req = '1;
        foreach (gcount[i]) gcount[i] = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            eg = (c % 2 == 0) ? (N'(1) << ((c / 2) % N)) : '0;
            check($sformatf("rot%0d_gnt", c), 32'(gnt), 32'(eg));
            check($sformatf("rot%0d_busy", c), 32'(busy), 32'(c % 2 == 0));
            if (c < 2 * N)
                for (int k = 0; k < N; k++) if (gnt[k]) gcount[k]++;
        end
        for (int k = 0; k < N; k++)
            check($sformatf("fair_cnt%0d", k), 32'(gcount[k]), 32'd1);

`ifdef REG_BANK_ARB_LOCK_EN
        // Locked requester 0 keeps winning; dropping lock before a closing
        // edge hands the next round to requester 1.
        rst = 1'b1; req = '0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; req = 4'b0011;
        for (int c = 0; c < 7; c++) begin
            lock = (c < 5) ? 4'b0001 : 4'b0000;
            @(posedge clk); @(negedge clk);
            eg = (c == 6) ? 4'b0010 : ((c % 2 == 0) ? 4'b0001 : 4'b0000);
            check($sformatf("lock%0d_gnt", c), 32'(gnt), 32'(eg));
        end
        lock = '0;
`endif

        // Random traffic against the model; requesters hold addr/data until granted.
        foreach (pend[k]) begin
            pend[k] = 0; p_addr[k] = '0; p_data[k] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 63) == 0);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k]   = 1;
                    p_addr[k] = AW'($urandom);
                    p_data[k] = DW'($urandom);
                end
                req[k]             = pend[k];
                addr[k*AW +: AW]   = p_addr[k];
                data[k*DW +: DW]   = p_data[k];
            end
            lock    = N'($urandom);
            rd_addr = AW'($urandom);
            @(posedge clk);
            model_step(done);
            if (done >= 0) pend[done] = 0;
            @(negedge clk);
            eg = m_wr ? (N'(1) << m_win) : '0;
            check("rand_gnt", 32'(gnt), 32'(eg));
            check("rand_busy", 32'(busy), 32'(m_wr));
            check("rand_rd", 32'(rd_data), 32'(m_rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
